mips_mc_controller: RTL
=======================

Name: mips_mc_controller

Overview:
- Multicycle main control FSM for the 32-bit MIPS datapath.
- Decodes the instruction opcode (op = instr[31:26]) and sequences fetch, decode, execute, memory and writeback.
- Produces the 2-bit aluop consumed directly by the ALU-control decoder, plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake during every memory access.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LB, 6'b100000, load byte
- OP_SB, 6'b101000, store byte
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- op  input  6  opcode from instruction register
- zero  input  1  ALU zero flag
- memready  input  1  memory access completes this cycle
- memread  output  1  memory read request
- memwrite  output  1  memory write request
- iord  output  1  address mux: 0 = PC, 1 = ALU out
- irwrite  output  1  instruction register load
- regdst  output  1  0 = rt, 1 = rd
- memtoreg  output  1  0 = ALU out, 1 = memory data
- regwrite  output  1  register file write
- alusrca  output  1  0 = PC, 1 = regA
- alusrcb  output  2  00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- aluop  output  2  00 = add, 01 = sub, 10 = use funct
- pcsrc  output  2  00 = ALU result, 01 = ALU out reg, 10 = jump target
- pcen  output  1  PC write enable
- illegal  output  1  one-cycle pulse when an unsupported opcode is decoded
- state  output  4  current state, for debug

Behaviour:
- State register updates on posedge clk.
- Asynchronous reset (reset = 0) forces state to FETCH immediately.
- While reset = 0, irwrite, pcen, regwrite, memwrite and illegal are forced to 0.
- While reset = 0, the remaining outputs show FETCH values: memread = 1, alusrcb = 01, all others 0.
- Reset mid-instruction abandons it with no partial write.
- Outputs are decoded combinationally from state (Moore). Exceptions:
  - irwrite and pcen in FETCH, and pcen in BEQEX, are qualified by inputs (Mealy).
  - illegal in DECODE depends on op.
- Any output not listed for a state is 0.
- State encoding and per-state behaviour:
  - FETCH (0): memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00; irwrite = memready, pcen = memready. Stay in FETCH while memready = 0, else go to DECODE.
  - DECODE (1): alusrca = 0, alusrcb = 11, aluop = 00 (precompute branch target). Next state by op: LB/SB -> MEMADR, RTYPE -> RTYPEEX, BEQ -> BEQEX, J -> JEX, ADDI -> ADDIEX. Any other op: illegal = 1 for this cycle, next state FETCH.
  - MEMADR (2): alusrca = 1, alusrcb = 10, aluop = 00. LB -> MEMRD, SB -> MEMWR.
  - MEMRD (3): memread = 1, iord = 1. Hold while memready = 0, else go to MEMWB.
  - MEMWB (4): regwrite = 1, memtoreg = 1, regdst = 0. Next FETCH.
  - MEMWR (5): memwrite = 1, iord = 1. Hold while memready = 0, else go to FETCH. memwrite stays high for the whole hold.
  - RTYPEEX (6): alusrca = 1, alusrcb = 00, aluop = 10. Next RTYPEWB.
  - RTYPEWB (7): regwrite = 1, regdst = 1, memtoreg = 0. Next FETCH.
  - BEQEX (8): alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, pcen = zero. Next FETCH.
  - JEX (9): pcsrc = 10, pcen = 1. Next FETCH.
  - ADDIEX (10): alusrca = 1, alusrcb = 10, aluop = 00. Next ADDIWB.
  - ADDIWB (11): regwrite = 1, regdst = 0, memtoreg = 0. Next FETCH.
- Encodings 12–15 are unreachable:
  - All outputs 0.
  - Next state FETCH.
  - illegal not asserted.
- op is sampled only in DECODE and MEMADR, so op changes in other states have no effect.
- Latency with memready always 1:
  - R-type 4 cycles; ADDI 4; LB 5; SB 4; BEQ 3; J 3.
  - Each cycle memready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- At most one of memread / memwrite is high in any cycle.
- regwrite and memwrite are never high together.

Test Plan:
- R-type: release reset, memready = 1, op = 000000 -> states 0,1,6,7,0. aluop = 10 in state 6. regwrite = 1 and regdst = 1 only in state 7. pcen = 1 only in FETCH.
- LB with stall: op = 100000, memready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. iord = 1 throughout MEMRD. memtoreg = 1 and regwrite = 1 in state 4.
- SB and fetch stall: memready = 0 for 3 cycles in FETCH -> irwrite = 0 and pcen = 0 during the stall, then 1 for exactly one cycle. Then SB path 1,2,5,0 with memwrite = 1 only in state 5.
- BEQ: zero = 1 -> pcen = 1, pcsrc = 01, aluop = 01 in BEQEX. Repeat with zero = 0 -> pcen = 0. Both return to FETCH.
- Illegal opcode: op = 111111 in DECODE -> illegal = 1 for one cycle, next state 0, no regwrite or memwrite asserted.
- Reset mid-MEMWR: assert reset = 0 asynchronously while memwrite = 1 -> memwrite drops to 0 without waiting for a clock edge and state = 0. After release, normal fetch resumes.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing, Moore outputs plus input-qualified irwrite/pcen.
// Latency 3-5 cycles per instruction; stalls in FETCH/MEMRD/MEMWR until memready, no other backpressure.
module mips_mc_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LB    = 6'b100000,
    parameter logic [5:0] OP_SB    = 6'b101000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_JEX     = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWB  = 4'd11;

    logic [3:0] cur_state;
    logic [3:0] nxt_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    assign state = cur_state;

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:   nxt_state = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == OP_LB || op == OP_SB) nxt_state = S_MEMADR;
                else if (op == OP_RTYPE)        nxt_state = S_RTYPEEX;
                else if (op == OP_BEQ)          nxt_state = S_BEQEX;
                else if (op == OP_J)            nxt_state = S_JEX;
                else if (op == OP_ADDI)         nxt_state = S_ADDIEX;
                else                            nxt_state = S_FETCH;
            end
            S_MEMADR:  nxt_state = (op == OP_SB) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt_state = memready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   nxt_state = S_FETCH;
            S_MEMWR:   nxt_state = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: nxt_state = S_RTYPEWB;
            S_RTYPEWB: nxt_state = S_FETCH;
            S_BEQEX:   nxt_state = S_FETCH;
            S_JEX:     nxt_state = S_FETCH;
            S_ADDIEX:  nxt_state = S_ADDIWB;
            S_ADDIWB:  nxt_state = S_FETCH;
            default:   nxt_state = S_FETCH;
        endcase
    end

    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        illegal  = 1'b0;
        // Reset overrides the decode so no write strobe can leak before the state register clears.
        if (!reset) begin
            memread = 1'b1;
            alusrcb = 2'b01;
        end else begin
            case (cur_state)
                S_FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = memready;
                    pcen    = memready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal = !(op == OP_LB || op == OP_SB || op == OP_RTYPE ||
                                op == OP_BEQ || op == OP_J || op == OP_ADDI);
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_RTYPEWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BEQEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    pcen    = zero;
                end
                S_JEX: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
